param_loader: RTL and testbench

Synthesizable, parametrised loader that replaces file-based parameter initialisation in the CNN datapath. It accepts a valid/ready stream of IN_W-bit two's-complement words and sign-extends each to DATA_W. It stores the words channel-major into an on-chip buffer of NUM_CH channels × DEPTH words. Once loading is complete, it serves random reads to the convolution and fully-connected stages.

---
 rtl/cnn_pkg.sv | 38 +++
 rtl/param_ram.sv | 44 ++++
 rtl/param_loader.sv | 157 +++++++++++++++
 tb/tb_param_loader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg
// Shared definitions for the CNN parameter-loading path:
//   - loader_state_t : loader FSM states (IDLE, LOAD, DONE)
//   - DEFAULT_DATA_W : default stored/read word width
//   - sign_extend()  : widens an in_w-bit two's-complement value to EXT_MAX_W bits
package cnn_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } loader_state_t;

   localparam int DEFAULT_DATA_W = 32;

   // Widest word the sign-extension helper handles; callers truncate the result.
   localparam int EXT_MAX_W = 64;
   localparam int EXT_IDX_W = 6;

   // Every bit at or above in_w copies bit in_w-1. When in_w equals the
   // caller's target width the value passes through unchanged.
   function automatic logic [EXT_MAX_W-1:0] sign_extend(
      input logic [EXT_MAX_W-1:0] val,
      input int                   in_w
   );
      logic [EXT_MAX_W-1:0] ext;
      logic                 sign_bit;
      sign_bit = val[EXT_IDX_W'(in_w - 1)];
      ext      = val;
      for (int i = 0; i < EXT_MAX_W; i++) begin
         if (i >= in_w) begin
            ext[i] = sign_bit;
         end
      end
      return ext;
   endfunction

endpackage

// File: rtl/param_ram.sv
// param_ram
// Simple dual-port buffer: one synchronous write port, one synchronous read
// port with read enable. No reset so it maps onto block RAM.
// Ports:
//   clk     in  clock
//   i_we    in  write enable
//   i_waddr in  write address
//   i_wdata in  write data
//   i_re    in  read enable; o_rdata only changes when this is high
//   i_raddr in  read address
//   o_rdata out registered read data
module param_ram #(
   parameter int DATA_W = 32,
   parameter int WORDS  = 200,
   parameter int AW     = 8
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [AW-1:0]     i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [0:WORDS-1];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Output register holds its value while i_re is low.
   always_ff @(posedge clk) begin
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/param_loader.sv
// param_loader
// Loads a valid/ready stream of IN_W-bit words, sign-extends them to DATA_W
// and stores them channel-major (NUM_CH channels x DEPTH words). Once loaded,
// serves random reads with one cycle of latency.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin/restart a load (ignored while loading)
//   in_data/in_valid  incoming word stream; in_ready high while loading
//   busy, done        load in progress / buffer complete and readable
//   rd_en/rd_ch/rd_addr  read request (serviced only when done)
//   rd_data/rd_valid/rd_err  read response one cycle later
module param_loader
   import cnn_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int IN_W   = 32,
   parameter int NUM_CH = 8,
   parameter int DEPTH  = 25,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [IN_W-1:0]   in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              busy,
   output logic              done,
   input  logic              rd_en,
   input  logic [CH_W-1:0]   rd_ch,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              rd_err
);

   localparam int RAM_WORDS = NUM_CH * DEPTH;
   localparam int RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

   loader_state_t     r_state;
   loader_state_t     w_state_next;
   logic [CH_W-1:0]   r_ch_cnt;
   logic [ADDR_W-1:0] r_addr_cnt;
   logic              r_rd_valid;
   logic              r_rd_err;
   logic              r_rd_zero;

   logic              w_xfer;
   logic              w_addr_wrap;
   logic              w_last;
   logic              w_enter_load;
   logic              w_rd_serve;
   logic              w_rd_oor;
   logic [RAM_AW-1:0] w_wr_addr;
   logic [RAM_AW-1:0] w_rd_addr;
   logic [DATA_W-1:0] w_wr_data;
   logic [DATA_W-1:0] w_ram_q;

   assign w_xfer       = in_valid && (r_state == LOAD);
   assign w_addr_wrap  = (r_addr_cnt == ADDR_W'(DEPTH - 1));
   assign w_last       = w_xfer && w_addr_wrap && (r_ch_cnt == CH_W'(NUM_CH - 1));
   assign w_enter_load = (r_state != LOAD) && (w_state_next == LOAD);

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) w_state_next = LOAD;
         end
         LOAD: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (w_last) w_state_next = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) w_state_next = LOAD;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // ---------------- write counters ----------------
   // Counters also return to 0 naturally after the final word, so a reload
   // and the post-load state agree.
   always_ff @(posedge clk) begin
      if (rst || w_enter_load) begin
         r_ch_cnt   <= '0;
         r_addr_cnt <= '0;
      end else if (w_xfer) begin
         if (w_addr_wrap) begin
            r_addr_cnt <= '0;
            r_ch_cnt   <= w_last ? '0 : r_ch_cnt + 1'b1;
         end else begin
            r_addr_cnt <= r_addr_cnt + 1'b1;
         end
      end
   end

   assign w_wr_addr = RAM_AW'(32'(r_ch_cnt) * 32'(DEPTH) + 32'(r_addr_cnt));
   assign w_wr_data = DATA_W'(sign_extend(EXT_MAX_W'(in_data), IN_W));

   // ---------------- read side ----------------
   // A start in DONE wins over a simultaneous read.
   assign w_rd_serve = rd_en && (r_state == DONE) && !start;
   assign w_rd_oor   = (32'(rd_ch) >= 32'(NUM_CH)) || (32'(rd_addr) >= 32'(DEPTH));
   assign w_rd_addr  = RAM_AW'(32'(rd_ch) * 32'(DEPTH) + 32'(rd_addr));

   // The RAM output register has no reset, so r_rd_zero forces rd_data to 0
   // after reset and for out-of-range responses. Unserviced requests leave
   // both the flag and the RAM register untouched, holding rd_data.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_valid <= 1'b0;
         r_rd_err   <= 1'b0;
         r_rd_zero  <= 1'b1;
      end else begin
         r_rd_valid <= w_rd_serve;
         r_rd_err   <= w_rd_serve && w_rd_oor;
         if (w_rd_serve) begin
            r_rd_zero <= w_rd_oor;
         end
      end
   end

   param_ram #(
      .DATA_W (DATA_W),
      .WORDS  (RAM_WORDS),
      .AW     (RAM_AW)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_xfer),
      .i_waddr (w_wr_addr),
      .i_wdata (w_wr_data),
      .i_re    (w_rd_serve && !w_rd_oor),
      .i_raddr (w_rd_addr),
      .o_rdata (w_ram_q)
   );

   assign rd_data  = r_rd_zero ? '0 : w_ram_q;
   assign rd_valid = r_rd_valid;
   assign rd_err   = r_rd_err;

endmodule

// File: tb/tb_param_loader.sv
// tb_param_loader
// Directed bench. DUT A: NUM_CH=2, DEPTH=4, 32-bit words, CH_W widened to 2
// so channel index 2 can be presented. DUT B: NUM_CH=2, DEPTH=3, 8-bit input
// sign-extended to 32 bits.
module tb_param_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- DUT A ----------------
   logic        a_rst = 1'b0, a_start = 1'b0, a_in_valid = 1'b0, a_rd_en = 1'b0;
   logic [31:0] a_in_data = '0;
   logic        a_in_ready, a_busy, a_done, a_rd_valid, a_rd_err;
   logic [1:0]  a_rd_ch = '0;
   logic [1:0]  a_rd_addr = '0;
   logic [31:0] a_rd_data;

   param_loader #(
      .DATA_W (32), .IN_W (32), .NUM_CH (2), .DEPTH (4), .CH_W (2), .ADDR_W (2)
   ) dut_a (
      .clk (clk), .rst (a_rst), .start (a_start),
      .in_data (a_in_data), .in_valid (a_in_valid), .in_ready (a_in_ready),
      .busy (a_busy), .done (a_done),
      .rd_en (a_rd_en), .rd_ch (a_rd_ch), .rd_addr (a_rd_addr),
      .rd_data (a_rd_data), .rd_valid (a_rd_valid), .rd_err (a_rd_err)
   );

   // ---------------- DUT B ----------------
   logic        b_rst = 1'b0, b_start = 1'b0, b_in_valid = 1'b0, b_rd_en = 1'b0;
   logic [7:0]  b_in_data = '0;
   logic        b_in_ready, b_busy, b_done, b_rd_valid, b_rd_err;
   logic [0:0]  b_rd_ch = '0;
   logic [1:0]  b_rd_addr = '0;
   logic [31:0] b_rd_data;

   param_loader #(
      .DATA_W (32), .IN_W (8), .NUM_CH (2), .DEPTH (3)
   ) dut_b (
      .clk (clk), .rst (b_rst), .start (b_start),
      .in_data (b_in_data), .in_valid (b_in_valid), .in_ready (b_in_ready),
      .busy (b_busy), .done (b_done),
      .rd_en (b_rd_en), .rd_ch (b_rd_ch), .rd_addr (b_rd_addr),
      .rd_data (b_rd_data), .rd_valid (b_rd_valid), .rd_err (b_rd_err)
   );

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s: %0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_a(input string tag);
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      check({tag, "_ready"}, 64'(a_in_ready), 64'(1));
      check({tag, "_busy"},  64'(a_busy),     64'(1));
      check({tag, "_done"},  64'(a_done),     64'(0));
   endtask

   // Streams base+0..base+7 into DUT A. With gaps, in_valid drops every third
   // cycle; with poke_start, start is pulsed in the middle of the stream.
   task automatic load_a(input int base, input bit gaps, input bit poke_start);
      int idx = 0;
      int cyc = 0;
      bit early = 1'b0;
      bit acc;
      while (idx < 8 && cyc < 100) begin
         a_in_valid = !(gaps && (cyc % 3 == 1));
         a_in_data  = 32'(base + idx);
         a_start    = poke_start && (cyc == 4);
         acc        = a_in_valid && a_in_ready;
         if (a_done) early = 1'b1;
         tick();
         if (acc) idx++;
         cyc++;
      end
      a_in_valid = 1'b0;
      a_start    = 1'b0;
      check("xfer_count",       64'(idx),        64'(8));
      check("done_not_early",   64'(early),      64'(0));
      check("done_after_last",  64'(a_done),     64'(1));
      check("busy_after_last",  64'(a_busy),     64'(0));
      check("ready_after_last", 64'(a_in_ready), 64'(0));
   endtask

   task automatic read_a(input int ch, input int addr, input logic [31:0] exp, input bit exp_err);
      a_rd_en   = 1'b1;
      a_rd_ch   = 2'(ch);
      a_rd_addr = 2'(addr);
      tick();
      a_rd_en = 1'b0;
      check($sformatf("a_rd(%0d,%0d)_valid", ch, addr), 64'(a_rd_valid), 64'(1));
      check($sformatf("a_rd(%0d,%0d)_err",   ch, addr), 64'(a_rd_err),   64'(exp_err));
      check($sformatf("a_rd(%0d,%0d)_data",  ch, addr), 64'(a_rd_data),  64'(exp));
   endtask

   task automatic readall_a(input int base);
      for (int c = 0; c < 2; c++) begin
         for (int ad = 0; ad < 4; ad++) begin
            read_a(c, ad, 32'(base + c * 4 + ad), 1'b0);
         end
      end
   endtask

   logic [7:0]  b_words [6] = '{8'h80, 8'h7F, 8'h00, 8'hFF, 8'h01, 8'hFE};
   logic [31:0] b_exp   [6] = '{32'hFFFFFF80, 32'h0000007F, 32'h00000000,
                                32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE};

   initial begin
      // ---------------- reset ----------------
      a_rst = 1'b1;
      b_rst = 1'b1;
      tick();
      tick();
      a_rst = 1'b0;
      b_rst = 1'b0;
      check("rst_ready",    64'(a_in_ready), 64'(0));
      check("rst_busy",     64'(a_busy),     64'(0));
      check("rst_done",     64'(a_done),     64'(0));
      check("rst_rd_valid", 64'(a_rd_valid), 64'(0));
      check("rst_rd_err",   64'(a_rd_err),   64'(0));
      check("rst_rd_data",  64'(a_rd_data),  64'(0));

      // Read in IDLE is not serviced.
      a_rd_en = 1'b1;
      tick();
      a_rd_en = 1'b0;
      check("idle_rd_valid", 64'(a_rd_valid), 64'(0));
      check("idle_rd_data",  64'(a_rd_data),  64'(0));

      // ---------------- 1: basic load 0..7 ----------------
      start_a("t1_start");
      load_a(0, 1'b0, 1'b0);
      readall_a(0);
      read_a(1, 2, 32'd6, 1'b0);
      tick();
      check("rd_valid_pulse", 64'(a_rd_valid), 64'(0));
      check("rd_data_hold",   64'(a_rd_data),  64'(6));

      // ---------------- 5: out-of-range reads ----------------
      read_a(2, 0, 32'd0, 1'b1);
      read_a(3, 3, 32'd0, 1'b1);
      read_a(0, 3, 32'd3, 1'b0);

      // ---------------- 3: gaps + start pulsed mid-load ----------------
      start_a("t3_start");
      load_a(20, 1'b1, 1'b1);
      readall_a(20);

      // ---------------- 4: reset after 3 transfers ----------------
      start_a("t4_start");
      a_in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a_in_data = 32'(50 + i);
         tick();
      end
      a_in_valid = 1'b0;
      a_rst = 1'b1;
      tick();
      a_rst = 1'b0;
      check("t4_rst_done",  64'(a_done),     64'(0));
      check("t4_rst_ready", 64'(a_in_ready), 64'(0));
      check("t4_rst_busy",  64'(a_busy),     64'(0));
      start_a("t4_restart");
      load_a(60, 1'b0, 1'b0);
      readall_a(60);

      // ---------------- 6: reload with start+rd_en together ----------------
      read_a(1, 1, 32'd65, 1'b0);
      a_start   = 1'b1;
      a_rd_en   = 1'b1;
      a_rd_ch   = 2'd0;
      a_rd_addr = 2'd0;
      tick();
      a_start = 1'b0;
      check("t6_done_drop",    64'(a_done),     64'(0));
      check("t6_busy",         64'(a_busy),     64'(1));
      check("t6_rd_not_serv",  64'(a_rd_valid), 64'(0));
      // rd_en held during LOAD: still no response, data holds.
      tick();
      a_rd_en = 1'b0;
      check("t6_load_rd_valid", 64'(a_rd_valid), 64'(0));
      check("t6_load_rd_hold",  64'(a_rd_data),  64'(65));
      load_a(100, 1'b0, 1'b0);
      readall_a(100);

      // ---------------- 2: sign extension on DUT B ----------------
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      check("b_start_ready", 64'(b_in_ready), 64'(1));
      b_in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         b_in_data = b_words[i];
         tick();
      end
      b_in_valid = 1'b0;
      check("b_done", 64'(b_done), 64'(1));
      for (int i = 0; i < 6; i++) begin
         b_rd_en   = 1'b1;
         b_rd_ch   = 1'(i / 3);
         b_rd_addr = 2'(i % 3);
         tick();
         b_rd_en = 1'b0;
         check($sformatf("b_rd%0d_valid", i), 64'(b_rd_valid), 64'(1));
         check($sformatf("b_rd%0d_data", i),  64'(b_rd_data),  64'(b_exp[i]));
      end
      b_rd_en   = 1'b1;
      b_rd_ch   = 1'd1;
      b_rd_addr = 2'd3;
      tick();
      b_rd_en = 1'b0;
      check("b_oor_valid", 64'(b_rd_valid), 64'(1));
      check("b_oor_err",   64'(b_rd_err),   64'(1));
      check("b_oor_data",  64'(b_rd_data),  64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
